mdu_seq: RTL and testbench
==========================

// Module: mdu_seq
// PURPOSE
//  Iterative multiply/divide sequencer for RV32M (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//  Sits beside the single-cycle ALU in EX. Decode routes M-ops here; EX stalls until resp_valid_o.
//  Runs shift-add multiply or restoring divide, one bit per cycle, with valid/ready on both sides.
// PARAMETERS
//  XLEN      32   operand/result width (from riscv_pkg; only 32 supported)
//  CNT_W     5    iteration counter width, = $clog2(XLEN)
// PORTS
//  clk_i         in   1     clock, all state on rising edge
//  rst_i         in   1     synchronous, active-high reset
//  flush_i       in   1     abort any op in flight (pipeline flush)
//  req_valid_i   in   1     request valid
//  req_ready_o   out  1     sequencer can accept (IDLE only)
//  req_op_i      in   3     mdu_op_e operation
//  req_a_i       in   XLEN  rs1 operand
//  req_b_i       in   XLEN  rs2 operand
//  resp_valid_o  out  1     result valid, held until accepted
//  resp_ready_i  in   1     consumer takes result
//  resp_result_o out  XLEN  result
//  busy_o        out  1     state != IDLE (stall source for hazard unit)
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, all regs 0; req_ready_o=1, resp_valid_o=0, resp_result_o=0, busy_o=0.
//  FSM: IDLE -> CALC -> FIX -> DONE -> IDLE.
//   IDLE: req_ready_o=1. On req_valid_i, latch op and operands.
//     Normal case -> CALC with cnt=XLEN-1.
//     Special divide case -> DONE directly, result loaded the same edge.
//   CALC: one iteration per cycle. Leave to FIX when cnt==0; else cnt-=1. Exactly XLEN cycles.
//   FIX: apply sign correction, load result register. 1 cycle.
//   DONE: resp_valid_o=1, resp_result_o stable. On resp_ready_i -> IDLE. No new accept in DONE.
//  Latency: accept edge at T; resp_valid_o high from T+XLEN+2 (34 cycles), or T+1 on special div.
//  Multiply: operands -> 33-bit.
//   Sign-extend if signed: MULH a,b; MULHSU a only. Zero-extend otherwise.
//   64-bit product with 33-bit adder per step; two's-complement via sign fixup in FIX.
//   MUL returns prod[31:0]. MULH/MULHSU/MULHU return prod[63:32].
//  Divide: restoring, on |a|, |b| for signed ops; 33-bit trial subtract per step.
//   FIX negates quotient if a[31]^b[31] (signed), and remainder if a[31] (signed).
//  Special divide cases, no iteration:
//   b==0: DIV/DIVU -> 32'hFFFF_FFFF; REM/REMU -> a.
//   Signed a==32'h8000_0000 and b==32'hFFFF_FFFF:
//     DIV -> 32'h8000_0000; REM -> 0.
//  Flush: flush_i in any state -> IDLE next edge.
//   resp_valid_o deasserts, result discarded, cnt cleared.
//   flush_i has priority over req_valid_i the same cycle: no accept.
//  Reset mid-op: identical to flush; every register returns to its reset value.
//  resp_ready_i outside DONE is ignored. req_* changes after accept are ignored.
// STRUCTURE
//  riscv_pkg additions:
//   typedef enum logic[2:0] mdu_op_e
//     {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU, MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU},
//     encoding = funct3.
//   typedef enum logic[1:0] mdu_state_e {MDU_IDLE, MDU_CALC, MDU_FIX, MDU_DONE}.
//  Single module, no sub-modules. The ALU adder is not reused: it drops the 33rd bit needed per step.
//  Local 33-bit add/sub is the only arithmetic in the loop.
// TESTING
//  MUL 7*6, resp_ready_i=1 -> resp 42 exactly 34 cycles after accept.
//   req_ready_o low from T+1 through DONE.
//  MULH 0x8000_0000*0x8000_0000 -> 0x4000_0000.
//   MULHU 0xFFFF_FFFF*0xFFFF_FFFF -> 0xFFFF_FFFE.
//   MULHSU -1*0xFFFF_FFFF -> 0xFFFF_FFFF.
//  DIV -7/2 -> 0xFFFF_FFFD (-3). REM -7/2 -> 0xFFFF_FFFF (-1).
//   DIVU 100/7 -> 14. REMU 100/7 -> 2.
//  DIVU 5/0 -> 0xFFFF_FFFF at T+1. REM 5/0 -> 5.
//   DIV 0x8000_0000/-1 -> 0x8000_0000. REM same operands -> 0.
//  Backpressure: hold resp_ready_i=0 for 10 cycles in DONE.
//   resp_valid_o and result stay stable; IDLE the cycle after resp_ready_i=1.
//  Flush at CALC cnt=15 with req_valid_i=1 same cycle -> IDLE, no accept, resp_valid_o never rises.
//   Next request 9*9 -> 81. Repeat the sequence using rst_i instead of flush_i.

Source files
------------

// File: rtl/mdu_seq_pkg.sv
// ============================================================================
// Module      : mdu_seq_pkg
// Description : Shared types and constants for the RV32M multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_seq_pkg;

    localparam int MDU_XLEN  = 32;
    localparam int MDU_CNT_W = $clog2(MDU_XLEN);

    // Encoding matches funct3 of the RV32M instructions.
    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_FIX  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_e;

    function automatic logic op_a_signed(input mdu_op_e op);
        return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    function automatic logic op_b_signed(input mdu_op_e op);
        return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_seq.sv
// ============================================================================
// Module      : mdu_seq
// Description : Iterative RV32M sequencer, shift-add multiply / restoring divide.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int XLEN  = MDU_XLEN,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  mdu_op_e         req_op_i,
    input  logic [XLEN-1:0] req_a_i,
    input  logic [XLEN-1:0] req_b_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_result_o,
    output logic            busy_o
);

    localparam logic [XLEN-1:0]  C_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] C_CNT_TOP = CNT_W'(XLEN - 1);

    mdu_state_e       state_q;
    mdu_op_e          op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  hi_q, lo_q, m_q, result_q;
    logic             neg_q, ready_q, valid_q, busy_q;

    // Request decode: magnitudes, sign fixup flag and the no-iteration cases.
    logic            a_neg, b_neg, div_zero, div_ovf, is_special, neg_init;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    always_comb begin
        a_neg       = op_a_signed(req_op_i) && req_a_i[XLEN-1];
        b_neg       = op_b_signed(req_op_i) && req_b_i[XLEN-1];
        a_mag       = a_neg ? (-req_a_i) : req_a_i;
        b_mag       = b_neg ? (-req_b_i) : req_b_i;
        div_zero    = (req_b_i == '0);
        div_ovf     = ((req_op_i == MDU_DIV) || (req_op_i == MDU_REM)) &&
                      (req_a_i == C_INT_MIN) && (req_b_i == '1);
        is_special  = req_op_i[2] && (div_zero || div_ovf);
        neg_init    = (req_op_i == MDU_REM) ? a_neg : (a_neg ^ b_neg);
        special_res = '0;
        case (req_op_i)
            MDU_DIV, MDU_DIVU: special_res = div_zero ? '1 : C_INT_MIN;
            MDU_REM, MDU_REMU: special_res = div_zero ? req_a_i : '0;
            default:           special_res = '0;
        endcase
    end

    // One iteration: the multiply adds the multiplicand into the high half,
    // the divide trial-subtracts the divisor from the shifted remainder.
    logic [XLEN+1:0] add_a, add_b, sum;
    logic            div_ok;
    logic [XLEN-1:0] hi_d, lo_d;

    always_comb begin
        add_a  = op_q[2] ? {1'b0, hi_q, lo_q[XLEN-1]} : {2'b00, hi_q};
        add_b  = op_q[2] ? ~{2'b00, m_q} : (lo_q[0] ? {2'b00, m_q} : '0);
        sum    = add_a + add_b + (XLEN+2)'(op_q[2]);
        div_ok = ~sum[XLEN+1];
        if (op_q[2]) begin
            hi_d = div_ok ? sum[XLEN-1:0] : add_a[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], div_ok};
        end else begin
            hi_d = sum[XLEN:1];
            lo_d = {sum[0], lo_q[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = neg_q ? (-prod) : prod;
        quo_fix  = neg_q ? (-lo_q) : lo_q;
        rem_fix  = neg_q ? (-hi_q) : hi_q;
        fix_res  = '0;
        case (op_q)
            MDU_MUL:                        fix_res = prod_fix[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:              fix_res = quo_fix;
            MDU_REM, MDU_REMU:              fix_res = rem_fix;
            default:                        fix_res = '0;
        endcase
    end

    // Flush behaves exactly like reset so an aborted op leaves no residue.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            state_q  <= MDU_IDLE;
            op_q     <= MDU_MUL;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                MDU_IDLE: begin
                    if (req_valid_i) begin
                        op_q    <= req_op_i;
                        neg_q   <= neg_init;
                        hi_q    <= '0;
                        lo_q    <= req_op_i[2] ? a_mag : b_mag;
                        m_q     <= req_op_i[2] ? b_mag : a_mag;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (is_special) begin
                            result_q <= special_res;
                            valid_q  <= 1'b1;
                            state_q  <= MDU_DONE;
                        end else begin
                            cnt_q    <= C_CNT_TOP;
                            state_q  <= MDU_CALC;
                        end
                    end
                end
                MDU_CALC: begin
                    hi_q <= hi_d;
                    lo_q <= lo_d;
                    if (cnt_q == '0) begin
                        state_q <= MDU_FIX;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                MDU_FIX: begin
                    result_q <= fix_res;
                    valid_q  <= 1'b1;
                    state_q  <= MDU_DONE;
                end
                MDU_DONE: begin
                    if (resp_ready_i) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= MDU_IDLE;
                    end
                end
                default: state_q <= MDU_IDLE;
            endcase
        end
    end

    assign req_ready_o   = ready_q;
    assign resp_valid_o  = valid_q;
    assign resp_result_o = result_q;
    assign busy_o        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_seq.sv
// ============================================================================
// Module      : tb_mdu_seq
// Description : Directed self-checking bench for the mdu_seq sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_seq;
    import mdu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i, flush_i, req_valid_i, resp_ready_i;
    mdu_op_e     req_op_i;
    logic [31:0] req_a_i, req_b_i;
    logic        req_ready_o, resp_valid_o, busy_o;
    logic [31:0] resp_result_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mdu_seq dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_result_o(resp_result_o),
        .busy_o       (busy_o)
    );

    typedef struct {
        mdu_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issues a request in the current cycle, waits for the response and
    // returns the cycle index (accept cycle = 0) where resp_valid_o is seen.
    task automatic issue(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input string name, output int lat, output logic rdy_bad);
        req_op_i    = op;
        req_a_i     = a;
        req_b_i     = b;
        req_valid_i = 1'b1;
        check({name, " req_ready"}, 32'(req_ready_o), 32'd1);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        req_a_i     = $urandom;
        req_b_i     = $urandom;
        req_op_i    = MDU_REMU;
        lat         = 1;
        rdy_bad     = 1'b0;
        while (!resp_valid_o && lat < 100) begin
            if (req_ready_o) rdy_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (req_ready_o) rdy_bad = 1'b1;
    endtask

    task automatic run_op(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input string name);
        int   lat;
        logic rdy_bad;
        resp_ready_i = 1'b1;
        issue(op, a, b, name, lat, rdy_bad);
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " result"}, resp_result_o, exp);
        check({name, " ready low while busy"}, 32'(rdy_bad), 32'd0);
        @(posedge clk); #1;
        check({name, " back to idle"}, {29'd0, resp_valid_o, req_ready_o, busy_o}, 32'b010);
    endtask

    task automatic abort_seq(input logic use_rst, input string name);
        int   lat;
        logic saw;
        resp_ready_i = 1'b1;
        req_op_i     = MDU_MUL;
        req_a_i      = 32'd123;
        req_b_i      = 32'd456;
        req_valid_i  = 1'b1;
        @(posedge clk); #1;
        req_valid_i  = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        // Iteration counter is at 15 here; abort with a competing request.
        if (use_rst) rst_i = 1'b1; else flush_i = 1'b1;
        req_valid_i = 1'b1;
        req_op_i    = MDU_MUL;
        req_a_i     = 32'd2;
        req_b_i     = 32'd3;
        @(posedge clk); #1;
        rst_i       = 1'b0;
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        check({name, " state after abort"},
              {28'd0, resp_valid_o, req_ready_o, busy_o, 1'b0}, 32'b0100);
        check({name, " result cleared"}, resp_result_o, 32'd0);
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (resp_valid_o || busy_o) saw = 1'b1;
        end
        check({name, " no response after abort"}, 32'(saw), 32'd0);
        run_op(MDU_MUL, 32'd9, 32'd9, 32'd81, 34, {name, " 9*9"});
    endtask

    initial begin
        int   lat;
        logic rdy_bad;
        logic stable_bad;

        vecs[0]  = '{MDU_MUL,    32'd7,          32'd6,          32'd42,         34, "MUL 7*6"};
        vecs[1]  = '{MDU_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  34, "MULH min*min"};
        vecs[2]  = '{MDU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  34, "MULHU max*max"};
        vecs[3]  = '{MDU_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  34, "MULHSU -1*max"};
        vecs[4]  = '{MDU_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34, "DIV -7/2"};
        vecs[5]  = '{MDU_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34, "REM -7/2"};
        vecs[6]  = '{MDU_DIVU,   32'd100,        32'd7,          32'd14,         34, "DIVU 100/7"};
        vecs[7]  = '{MDU_REMU,   32'd100,        32'd7,          32'd2,          34, "REMU 100/7"};
        vecs[8]  = '{MDU_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF,  1,  "DIVU 5/0"};
        vecs[9]  = '{MDU_REM,    32'd5,          32'd0,          32'd5,          1,  "REM 5/0"};
        vecs[10] = '{MDU_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  "DIV min/-1"};
        vecs[11] = '{MDU_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  "REM min/-1"};
        vecs[12] = '{MDU_MUL,    32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  34, "MUL -3*5"};
        vecs[13] = '{MDU_MULH,   32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF,  34, "MULH -3*5"};
        vecs[14] = '{MDU_DIV,    32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34, "DIV 7/-2"};
        vecs[15] = '{MDU_REM,    32'd7,          32'hFFFF_FFFE,  32'd1,          34, "REM 7/-2"};
        vecs[16] = '{MDU_DIVU,   32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34, "DIVU max/1"};
        vecs[17] = '{MDU_REMU,   32'hFFFF_FFFF,  32'h10,         32'h0000_000F,  34, "REMU max/16"};
        vecs[18] = '{MDU_DIV,    32'h8000_0000,  32'd2,          32'hC000_0000,  34, "DIV min/2"};
        vecs[19] = '{MDU_REM,    32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1,  "REM -5/0"};

        rst_i        = 1'b1;
        flush_i      = 1'b0;
        req_valid_i  = 1'b0;
        resp_ready_i = 1'b0;
        req_op_i     = MDU_MUL;
        req_a_i      = '0;
        req_b_i      = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        check("reset ready/valid/busy",
              {29'd0, req_ready_o, resp_valid_o, busy_o}, 32'b100);
        check("reset result", resp_result_o, 32'd0);

        foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
                                 vecs[i].lat, vecs[i].name);

        // Backpressure: result must hold while the consumer stalls.
        resp_ready_i = 1'b0;
        issue(MDU_DIVU, 32'd100, 32'd7, "backpressure", lat, rdy_bad);
        check("backpressure latency", 32'(lat), 32'd34);
        stable_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!resp_valid_o || resp_result_o !== 32'd14 || req_ready_o) stable_bad = 1'b1;
            @(posedge clk); #1;
        end
        check("backpressure hold", 32'(stable_bad), 32'd0);
        check("backpressure result", resp_result_o, 32'd14);
        resp_ready_i = 1'b1;
        @(posedge clk); #1;
        check("backpressure release",
              {29'd0, resp_valid_o, req_ready_o, busy_o}, 32'b010);

        abort_seq(1'b0, "flush");
        abort_seq(1'b1, "reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
